// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the counter sequencer: controller states,
// default timing constants and the wrap-around step helper.
package cnt_seq_pkg;

  // 50 MHz clock: one counter step per second, 20 ms button settle time
  localparam int DEF_TICK_DIV   = 50_000_000;
  localparam int DEF_DEB_CYCLES = 1_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Value the controlled counter will hold after one step in direction up
  function automatic logic [7:0] step_val(input logic [7:0] val, input logic up);
    logic [7:0] res;
    if (up) begin
      res = val + 8'd1;
    end else begin
      res = val - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional level debounce
// (enabled by macro CNT_SEQ_DEBOUNCE_EN), and rising-edge detector that
// emits a registered one-cycle press pulse.
module btn_debounce
  import cnt_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic Clk50MHz,
  input  logic RST,
  input  logic btn,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic prev_r;
  logic press_r;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef CNT_SEQ_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] stab_r;
  logic          level_r;

  // Accept a new level only once the synchronized input has disagreed
  // with the accepted level for DEB_CYCLES consecutive samples
  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      stab_r  <= '0;
      level_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      stab_r  <= '0;
      level_r <= level_r;
    end else if (stab_r == CW'(DEB_CYCLES - 1)) begin
      stab_r  <= '0;
      level_r <= sync2_r;
    end else begin
      stab_r  <= stab_r + CW'(1);
      level_r <= level_r;
    end
  end

  assign level_s = level_r;
`else
  // DEB_CYCLES has no function without debouncing; tie it off to an
  // intentionally unused net
  logic deb_unused_s;
  assign deb_unused_s = (DEB_CYCLES > 0);
  assign level_s      = sync2_r;
`endif

  // One-cycle pulse on each accepted low-to-high transition
  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      prev_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      prev_r  <= level_s;
      press_r <= level_s & ~prev_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Counter sequencer: turns start/stop, direction and clear buttons into
// step/clear strobes for an external 8-bit wrap-around up/down counter,
// with an optional stop-at-target. Button debouncing is selected with
// macro CNT_SEQ_DEBOUNCE_EN (default build: synchronize + edge detect only).
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       Clk50MHz,
  input  logic       RST,
  input  logic       btn_ss,
  input  logic       btn_ud,
  input  logic       btn_clr,
  input  logic       stop_en,
  input  logic [7:0] target,
  input  logic [7:0] cnt_val,
  output logic       cnt_en,
  output logic       cnt_ud,
  output logic       cnt_clr,
  output logic       busy,
  output logic       done
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic ss_p_s;
  logic ud_p_s;
  logic clr_p_s;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ss (
    .Clk50MHz (Clk50MHz),
    .RST      (RST),
    .btn      (btn_ss),
    .press    (ss_p_s)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ud (
    .Clk50MHz (Clk50MHz),
    .RST      (RST),
    .btn      (btn_ud),
    .press    (ud_p_s)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clr (
    .Clk50MHz (Clk50MHz),
    .RST      (RST),
    .btn      (btn_clr),
    .press    (clr_p_s)
  );

  seq_state_t    state_r;
  logic          dir_r;
  logic [PW-1:0] presc_r;
  logic          stop_pend_r;
  logic          cnt_en_r;
  logic          cnt_ud_r;
  logic          cnt_clr_r;
  logic          busy_r;
  logic          done_r;

  logic          tick_s;
  logic [7:0]    next_s;
  logic          hit_s;
  logic          dir_nx_s;

  // Step decision and target compare always use the direction in force
  // before any coincident ud press
  assign tick_s   = (state_r == RUN) && (presc_r == PRESC_LAST);
  assign next_s   = step_val(cnt_val, dir_r);
  assign hit_s    = stop_en && (next_s == target);
  assign dir_nx_s = ud_p_s ? ~dir_r : dir_r;

  // Sequencer FSM with prescaler and registered strobes/status.
  // A stop hit is committed at the tick and becomes DONE one cycle after
  // the final strobe; only clr can cancel it.
  always_ff @(posedge Clk50MHz) begin
    if (RST) begin
      state_r     <= IDLE;
      dir_r       <= 1'b1;
      presc_r     <= '0;
      stop_pend_r <= 1'b0;
      cnt_en_r    <= 1'b0;
      cnt_ud_r    <= 1'b1;
      cnt_clr_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else if (clr_p_s) begin
      state_r     <= IDLE;
      dir_r       <= 1'b1;
      presc_r     <= '0;
      stop_pend_r <= 1'b0;
      cnt_en_r    <= 1'b0;
      cnt_ud_r    <= 1'b1;
      cnt_clr_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      dir_r     <= dir_nx_s;
      cnt_ud_r  <= dir_nx_s;
      cnt_clr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          presc_r     <= '0;
          stop_pend_r <= 1'b0;
          cnt_en_r    <= 1'b0;
          done_r      <= 1'b0;
          if (ss_p_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (stop_pend_r) begin
            state_r     <= DONE;
            presc_r     <= '0;
            stop_pend_r <= 1'b0;
            cnt_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else if (tick_s) begin
            presc_r  <= '0;
            cnt_en_r <= 1'b1;
            done_r   <= 1'b0;
            if (ss_p_s) begin
              state_r     <= PAUSE;
              stop_pend_r <= 1'b0;
              busy_r      <= 1'b0;
            end else begin
              state_r     <= RUN;
              stop_pend_r <= hit_s;
              busy_r      <= 1'b1;
            end
          end else if (ss_p_s) begin
            state_r     <= PAUSE;
            presc_r     <= '0;
            stop_pend_r <= 1'b0;
            cnt_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
          end else begin
            state_r     <= RUN;
            presc_r     <= presc_r + PW'(1);
            stop_pend_r <= 1'b0;
            cnt_en_r    <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        PAUSE: begin
          presc_r     <= '0;
          stop_pend_r <= 1'b0;
          cnt_en_r    <= 1'b0;
          done_r      <= 1'b0;
          if (ss_p_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= PAUSE;
            busy_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r     <= DONE;
          presc_r     <= '0;
          stop_pend_r <= 1'b0;
          cnt_en_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          presc_r     <= '0;
          stop_pend_r <= 1'b0;
          cnt_en_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en  = cnt_en_r;
  assign cnt_ud  = cnt_ud_r;
  assign cnt_clr = cnt_clr_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, Clk50MHz cycles per counter step (1 Hz).
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, stable cycles required to accept a button level (20 ms).
REQ-003 SHALL have port Clk50MHz  input  1  system clock; all logic on its rising edge, no derived clocks.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports btn_ss, btn_ud, btn_clr  input  1 each  raw asynchronous buttons (start/stop, direction toggle, clear), active-high.
REQ-006 SHALL have ports stop_en  input  1 (enable stop-at-target) and target  input  8 (stop value).
REQ-007 SHALL have port cnt_val  input  8  current value of the controlled 8-bit wrap-around up/down counter.
REQ-008 SHALL have ports cnt_en  output  1 (one-cycle step strobe), cnt_ud  output  1 (1=up, 0=down) and cnt_clr  output  1 (one-cycle clear strobe).
REQ-009 SHALL have ports busy  output  1 (state RUN) and done  output  1 (state DONE); all outputs registered.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer and rising-edge detector, giving a one-cycle press pulse per press.
REQ-011 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-012 SHALL transition on ss press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ss press in DONE ignored.
REQ-013 SHALL, on clr press in any state, go to IDLE, set dir=1, and pulse cnt_clr for exactly one cycle.
REQ-014 SHALL toggle dir on ud press in IDLE, RUN, PAUSE, DONE; cnt_ud reflects dir from the next cycle.
REQ-015 SHALL run prescaler 0..TICK_DIV-1 only in RUN; held at 0 in every other state, so first cnt_en after entering RUN occurs exactly TICK_DIV cycles later.
REQ-016 SHALL pulse cnt_en for one cycle when prescaler equals TICK_DIV-1 in RUN, then restart at 0.
REQ-017 SHALL compute next = dir ? cnt_val+1 : cnt_val-1 modulo 256 (0xFF->0x00 up, 0x00->0xFF down).
REQ-018 SHALL, when cnt_en fires with stop_en=1 and next==target, still issue that cnt_en and enter DONE the following cycle.
REQ-019 SHALL with stop_en=0 run indefinitely, wrapping.
REQ-020 SHALL give priority clr > ss > tick-stop: clr press overrides all; ss press coinciding with a tick issues the tick and enters PAUSE.
REQ-021 SHALL, on ud press coinciding with a tick, use the old dir for that tick and its target compare.

Reset
REQ-022 SHALL on RST: state IDLE, dir=1, prescaler=0, synchronizer/debounce state cleared, cnt_en=0, cnt_clr=0, cnt_ud=1, busy=0, done=0.
REQ-023 SHALL treat RST mid-RUN as full reset; no cnt_en or cnt_clr in the cycle after RST deasserts.

Configuration
REQ-024 SHALL, with macro CNT_SEQ_DEBOUNCE_EN defined, accept a synchronized button level only after stable for DEB_CYCLES consecutive cycles; press pulse is DEB_CYCLES+3 cycles after a clean raw rise.
REQ-025 SHALL, without CNT_SEQ_DEBOUNCE_EN, omit debounce logic; press pulse is 3 cycles after raw rise (state/outputs update one cycle later).

Structure
REQ-026 SHALL place state enum (IDLE, RUN, PAUSE, DONE) and default TICK_DIV/DEB_CYCLES constants in shared package cnt_seq_pkg.
REQ-027 SHALL implement synchronizer+debounce+edge detect as sub-module btn_debounce, instantiated three times.

Verification (TICK_DIV=10, DEB_CYCLES=4)
REQ-028 SHALL cover: RST, ss press -> busy=1, cnt_en pulses every 10 cycles, first exactly 10 cycles after RUN entry, cnt_ud=1.
REQ-029 SHALL cover: cnt_val=0x00, dir down, tick -> next=0xFF; stop_en=1,target=0xFF -> one cnt_en, then done=1, no further cnt_en.
REQ-030 SHALL cover: RUN, ss press in same cycle as tick -> that cnt_en issued, state PAUSE, no cnt_en for 50 cycles; second ss -> resumes 10 cycles later.
REQ-031 SHALL cover: clr and ss pressed simultaneously in RUN -> state IDLE, one-cycle cnt_clr, cnt_ud=1, busy=0.
REQ-032 SHALL cover with CNT_SEQ_DEBOUNCE_EN: btn_ss glitch high 2 cycles -> no transition; high 6 cycles -> exactly one IDLE->RUN.
